// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter (fetch = 0, data = 1) with fixed-latency strobes.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of data-first priority.
module mem_port_arbiter #(
    parameter int AW      = 11,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          gid_q, gid_d;
    logic [DW-1:0] f_rdata_q, f_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q;
    logic          win_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;

    // Tie goes to the requester not granted last; pointer follows every grant.
    always_comb begin
        rr_d = rr_q;
        if (f_req && d_req) begin
            win_s = rr_q;
        end else begin
            win_s = d_req;
        end
        if ((state_q == ST_IDLE) && (f_req || d_req)) begin
            rr_d = ~win_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Data path wins every tie; a lone fetch request still wins.
    always_comb begin
        win_s = d_req;
    end
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        gid_d     = gid_q;
        f_rdata_d = f_rdata_q;
        d_rdata_d = d_rdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (f_req || d_req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = 4'd0;
                    gid_d   = win_s;
                    if (win_s) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                    end else begin
                        addr_d  = f_addr;
                        we_d    = 1'b0;
                        wdata_d = wdata_q;
                    end
                    rd_d = ~we_d;
                    wr_d = we_d;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_RESP;
                    // Writes leave both read-data registers untouched.
                    if (!we_q && gid_q) begin
                        d_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        f_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if (gid_q) begin
                        d_ack_d = 1'b1;
                    end else begin
                        f_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    rd_d  = ~we_q;
                    wr_d  = we_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            gid_q     <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            gid_q     <= gid_d;
            f_rdata_q <= f_rdata_d;
            d_rdata_q <= d_rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            f_ack_q   <= f_ack_d;
            d_ack_q   <= d_ack_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign f_ack     = f_ack_q;
    assign f_rdata   = f_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_rdata   = d_rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_wr    = wr_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;

endmodule
